// File: rtl/loader_pkg.sv
// Shared types for the flash boot loader: FSM states, error codes and the
// status flag bundle that is registered alongside the state.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_CSUM  = 2'd3
  } err_code_t;

  typedef struct packed {
    logic core_rst;
    logic busy;
    logic done;
    logic err;
  } status_t;

  // Status flags implied by a state; stored with the state so outputs are registered.
  function automatic status_t state_status(loader_state_t s);
    status_t st;
    st.core_rst = (s != DONE);
    st.busy     = (s == COUNT) || (s == DATA) || (s == CSUM);
    st.done     = (s == DONE);
    st.err      = (s == ERROR);
    return st;
  endfunction

endpackage

// File: rtl/flash_loader_if.sv
// Host word stream (valid/ready) and memory write port of the boot loader.
// master = host/memory side, slave = the loader.
interface flash_loader_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             mem_wr_en;
  logic             mem_wr_ready;
  logic [WIDTH-1:0] mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;

  modport master (
    output in_valid, in_data, mem_wr_ready,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  in_valid, in_data, mem_wr_ready,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/loader_wr_reg.sv
// One-entry write register in front of the memory write port. Address and
// data stay stable while a write waits for i_wr_ready; a load on the same
// edge as a completion refills the register without a bubble.
module loader_wr_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_wr_en,
  output logic [WIDTH-1:0] o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  input  logic             i_wr_ready
);

  logic             r_en;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_data;

  // Load a new entry, or retire the current one when the memory takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_en   <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (r_en && i_wr_ready) begin
      r_en <= 1'b0;
    end
  end

  assign o_ready   = !r_en || i_wr_ready;
  assign o_wr_en   = r_en;
  assign o_wr_addr = r_addr;
  assign o_wr_data = r_data;

endmodule

// File: rtl/flash_loader.sv
// Streaming boot loader: takes [base, count, data x count, checksum] from the
// host stream, writes the data words to consecutive word addresses and keeps
// the core in reset until the image checksum matches.
module flash_loader
  import loader_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int MAX_WORDS = 1024,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  flash_loader_if.slave    bus,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int               BYTES      = WIDTH / 8;
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(BYTES - 1);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_WORDS);

  loader_state_t    r_state;
  status_t          r_status;
  err_code_t        r_err_code;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_words;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_load;
  logic             w_wr_ready;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic [WIDTH-1:0] w_load_addr;
  logic [WIDTH-1:0] w_csum_total;
  logic [CNT_W-1:0] w_words_inc;
  logic             w_misaligned;

  // Input acceptance: DATA is gated by the write register, CSUM waits for the last write to drain.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE, COUNT: w_in_ready = 1'b1;
        DATA:        w_in_ready = w_wr_ready;
        CSUM:        w_in_ready = !w_wr_en;
        default:     w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_load       = w_accept && (r_state == DATA);
  assign w_load_addr  = r_base + WIDTH'(r_words) * STEP;
  assign w_csum_total = r_sum + bus.in_data;
  assign w_words_inc  = r_words + CNT_W'(1);
  assign w_misaligned = (bus.in_data & ALIGN_MASK) != '0;

  loader_wr_reg #(
    .WIDTH (WIDTH)
  ) u_wr_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_addr     (w_load_addr),
    .i_data     (bus.in_data),
    .o_ready    (w_wr_ready),
    .o_wr_en    (w_wr_en),
    .o_wr_addr  (w_wr_addr),
    .o_wr_data  (w_wr_data),
    .i_wr_ready (bus.mem_wr_ready)
  );

  // Frame parser FSM; status flags are registered together with each state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_status   <= state_status(IDLE);
      r_err_code <= ERR_NONE;
      r_base     <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_words    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
              r_state    <= ERROR;
              r_status   <= state_status(ERROR);
              r_err_code <= ERR_ALIGN;
            end else begin
              r_base   <= bus.in_data;
              r_state  <= COUNT;
              r_status <= state_status(COUNT);
            end
          end
        end
        COUNT: begin
          if (w_accept) begin
            r_sum   <= '0;
            r_words <= '0;
            if (bus.in_data > MAX_W) begin
              r_state    <= ERROR;
              r_status   <= state_status(ERROR);
              r_err_code <= ERR_LEN;
            end else if (bus.in_data == '0) begin
              r_count  <= '0;
              r_state  <= CSUM;
              r_status <= state_status(CSUM);
            end else begin
              r_count  <= CNT_W'(bus.in_data);
              r_state  <= DATA;
              r_status <= state_status(DATA);
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_sum   <= r_sum + bus.in_data;
            r_words <= w_words_inc;
            if (w_words_inc == r_count) begin
              r_state  <= CSUM;
              r_status <= state_status(CSUM);
            end
          end
        end
        CSUM: begin
          if (w_accept) begin
            if (w_csum_total == '0) begin
              r_state  <= DONE;
              r_status <= state_status(DONE);
            end else begin
              r_state    <= ERROR;
              r_status   <= state_status(ERROR);
              r_err_code <= ERR_CSUM;
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state  <= IDLE;
            r_status <= state_status(IDLE);
          end
        end
        ERROR: begin
          if (start) begin
            r_state    <= IDLE;
            r_status   <= state_status(IDLE);
            r_err_code <= ERR_NONE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_status <= state_status(IDLE);
        end
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.mem_wr_en   = w_wr_en;
  assign bus.mem_wr_addr = w_wr_addr;
  assign bus.mem_wr_data = w_wr_data;

  assign core_rst     = r_status.core_rst;
  assign busy         = r_status.busy;
  assign done         = r_status.done;
  assign err          = r_status.err;
  assign err_code     = r_err_code;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader: frames are driven word by word, expected
// memory writes are queued as data is sent and popped as writes complete.
module tb_flash_loader;

  localparam int WIDTH     = 32;
  localparam int MAX_WORDS = 1024;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic             core_rst;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] words_loaded;

  flash_loader_if #(.WIDTH(WIDTH)) bus ();

  flash_loader #(
    .WIDTH     (WIDTH),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          n_writes = 0;
  logic [63:0] exp_q[$];
  logic [31:0] data_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until the loader takes it (bounded).
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Full frame from data_q; expected writes are queued before each data word.
  task automatic send_frame(input logic [31:0] base, input logic [31:0] cnt,
                            input bit good_csum, input logic [31:0] bad_csum);
    logic [31:0] sum;
    sum = '0;
    send_word(base);
    send_word(cnt);
    for (int i = 0; i < data_q.size(); i++) begin
      exp_q.push_back({base + 32'(i) * 32'd4, data_q[i]});
      sum = sum + data_q[i];
      send_word(data_q[i]);
    end
    send_word(good_csum ? (32'd0 - sum) : bad_csum);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 64'(done || err), 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Write monitor: pops the scoreboard on each completed write, checks hold while stalled.
  logic        held_valid = 1'b0;
  logic [31:0] held_addr;
  logic [31:0] held_data;
  always @(negedge clk) begin
    if (!rst && bus.mem_wr_en) begin
      if (held_valid) begin
        check("wr_addr_hold", 64'(bus.mem_wr_addr), 64'(held_addr));
        check("wr_data_hold", 64'(bus.mem_wr_data), 64'(held_data));
      end
      if (bus.mem_wr_ready) begin
        logic [63:0] e;
        n_writes++;
        held_valid = 1'b0;
        $display("write @%08h = %08h", bus.mem_wr_addr, bus.mem_wr_data);
        if (exp_q.size() == 0) begin
          check("write_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.mem_wr_addr), 64'(e[63:32]));
          check("wr_data", 64'(bus.mem_wr_data), 64'(e[31:0]));
        end
      end else begin
        held_valid = 1'b1;
        held_addr  = bus.mem_wr_addr;
        held_data  = bus.mem_wr_data;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst              = 1'b1;
    start            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.mem_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("rst_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus.mem_wr_data), 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_flags", 64'({busy, done, err}), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // 1: basic two-word frame
    data_q = '{32'h01002083, 32'h00008133};
    w0 = n_writes;
    send_frame(32'h0, 32'd2, 1'b1, 32'h0);
    wait_end();
    check("t1_done", 64'(done), 64'd1);
    check("t1_core_rst", 64'(core_rst), 64'd0);
    check("t1_words", 64'(words_loaded), 64'd2);
    check("t1_nwrites", 64'(n_writes - w0), 64'd2);
    check("t1_busy", 64'(busy), 64'd0);
    step();
    pulse_start();
    @(negedge clk);
    check("t1_restart_core_rst", 64'(core_rst), 64'd1);
    check("t1_restart_done", 64'(done), 64'd0);
    step();

    // 2: same frame, memory stalls the first write for 3 cycles
    w0 = n_writes;
    bus.mem_wr_ready = 1'b0;
    fork
      send_frame(32'h0, 32'd2, 1'b1, 32'h0);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mem_wr_en && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("t2_stall_seen", 64'(bus.mem_wr_en), 64'd1);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("t2_stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        step();
        bus.mem_wr_ready = 1'b1;
      end
    join
    wait_end();
    check("t2_done", 64'(done), 64'd1);
    check("t2_nwrites", 64'(n_writes - w0), 64'd2);
    step();
    pulse_start();

    // 3: misaligned base
    w0 = n_writes;
    send_word(32'h2);
    @(negedge clk);
    check("t3_err", 64'(err), 64'd1);
    check("t3_err_code", 64'(err_code), 64'd1);
    check("t3_core_rst", 64'(core_rst), 64'd1);
    check("t3_in_ready", 64'(bus.in_ready), 64'd0);
    check("t3_nwrites", 64'(n_writes - w0), 64'd0);
    step();
    pulse_start();
    @(negedge clk);
    check("t3_clr_err", 64'(err), 64'd0);
    check("t3_clr_code", 64'(err_code), 64'd0);
    check("t3_idle_ready", 64'(bus.in_ready), 64'd1);
    step();

    // 4: count too large, then an empty image
    send_word(32'h0);
    send_word(32'(MAX_WORDS + 1));
    @(negedge clk);
    check("t4_err_code", 64'(err_code), 64'd2);
    check("t4_err", 64'(err), 64'd1);
    step();
    pulse_start();
    w0 = n_writes;
    data_q = {};
    send_frame(32'h100, 32'd0, 1'b0, 32'h0);
    wait_end();
    check("t4_zero_done", 64'(done), 64'd1);
    check("t4_zero_words", 64'(words_loaded), 64'd0);
    check("t4_zero_nwrites", 64'(n_writes - w0), 64'd0);
    step();
    pulse_start();

    // 5: bad checksum after the write has landed
    data_q = '{32'hdeadbeef};
    send_frame(32'h10, 32'd1, 1'b0, 32'h0);
    wait_end();
    check("t5_err_code", 64'(err_code), 64'd3);
    check("t5_core_rst", 64'(core_rst), 64'd1);
    check("t5_done", 64'(done), 64'd0);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);
    step();
    pulse_start();

    // 6: reset while a write is pending, then a fresh frame
    bus.mem_wr_ready = 1'b0;
    send_word(32'h40);
    send_word(32'd4);
    send_word(32'h12345678);
    @(negedge clk);
    check("t6_pending", 64'(bus.mem_wr_en), 64'd1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("t6_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("t6_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_words", 64'(words_loaded), 64'd0);
    check("t6_core_rst", 64'(core_rst), 64'd1);
    check("t6_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    bus.mem_wr_ready = 1'b1;
    step();
    data_q = '{32'h00000013, 32'hcafef00d, 32'h8badf00d};
    w0 = n_writes;
    send_frame(32'h80, 32'd3, 1'b1, 32'h0);
    wait_end();
    check("t6_done", 64'(done), 64'd1);
    check("t6_words3", 64'(words_loaded), 64'd3);
    check("t6_nwrites", 64'(n_writes - w0), 64'd3);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
